// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM states, mode encodings and counter sizing
package serial_subtractor_pkg;
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ABS = 1'b1;
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done request bus with operands and held result
interface serial_subtractor_if #(parameter int WIDTH = 16);
  logic             start;
  logic             mode;
  logic             bin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  modport master(output start, mode, bin, a, b, input busy, done, diff, bout, zero);
  modport slave(input start, mode, bin, a, b, output busy, done, diff, bout, zero);
endinterface

// File: rtl/serial_subtractor_digit.sv
// digit_subtractor: combinational DIGIT-bit borrow-ripple subtractor x - y - bin
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);
  logic [DIGIT:0] w_b;
  assign w_b[0] = bin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign d[i]     = x[i] ^ y[i] ^ w_b[i];
    assign w_b[i+1] = (~x[i] & (y[i] ^ w_b[i])) | (y[i] & w_b[i]);
  end
  assign bout = w_b[DIGIT];
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial A-B-bin or |A-B| with start/busy/done handshake
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave s
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_diff, w_acc;
  logic             r_borrow, r_mode, r_bout, r_zero;
  logic [DIGIT-1:0] w_x, w_y, w_d;
  logic             w_bo, w_last;
  // PASS2 swaps the operands so the slice datapath computes b - a
  assign w_x    = (r_state == PASS2) ? r_b[r_cnt*DIGIT +: DIGIT] : r_a[r_cnt*DIGIT +: DIGIT];
  assign w_y    = (r_state == PASS2) ? r_a[r_cnt*DIGIT +: DIGIT] : r_b[r_cnt*DIGIT +: DIGIT];
  assign w_last = r_cnt == CW'(N - 1);
  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .x(w_x), .y(w_y), .bin(r_borrow), .d(w_d), .bout(w_bo)
  );
  always_comb begin
    w_acc = r_acc;
    w_acc[r_cnt*DIGIT +: DIGIT] = w_d;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = s.start ? PASS1 : IDLE;
      PASS1:   w_next = w_last ? ((r_mode == MODE_ABS && w_bo) ? PASS2 : DONE) : PASS1;
      PASS2:   w_next = w_last ? DONE : PASS2;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_borrow <= 1'b0;
      r_mode   <= MODE_SUB;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (s.start) begin
          r_a      <= s.a;
          r_b      <= s.b;
          r_mode   <= s.mode;
          r_borrow <= (s.mode == MODE_SUB) & s.bin;
          r_cnt    <= '0;
          r_acc    <= '0;
        end
        PASS1, PASS2: begin
          r_acc    <= w_acc;
          r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
          r_borrow <= w_last ? 1'b0 : w_bo;
          if (r_state == PASS1 && w_last) r_bout <= w_bo;
          if (w_next == DONE) begin
            r_diff <= w_acc;
            r_zero <= w_acc == '0;
          end
        end
        default: ;
      endcase
    end
  end
  assign s.busy = r_state != IDLE;
  assign s.done = r_state == DONE;
  assign s.diff = r_diff;
  assign s.bout = r_bout;
  assign s.zero = r_zero;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed, back-to-back, reset and exhaustive checks vs arithmetic model
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(16)) m ();
  serial_subtractor_if #(.WIDTH(4)) e1 ();
  serial_subtractor_if #(.WIDTH(4)) e2 ();
  serial_subtractor_if #(.WIDTH(4)) e4 ();
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (.clk(clk), .rst(rst), .s(m));
  serial_subtractor #(.WIDTH(4), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .s(e1));
  serial_subtractor #(.WIDTH(4), .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .s(e2));
  serial_subtractor #(.WIDTH(4), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .s(e4));

  function automatic void ref_model(input int w, input int a, input int b, input bit bin,
                                    input bit mode, output int d, output bit bo, output bit z);
    int mask;
    mask = (1 << w) - 1;
    if (mode) begin
      bo = a < b;
      d  = bo ? b - a : a - b;
    end else begin
      bo = a < b + int'(bin);
      d  = (a - b - int'(bin)) & mask;
    end
    z = d == 0;
  endfunction

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin, input logic mode,
                      output int lat, output int busy_n);
    @(negedge clk);
    m.a = a; m.b = b; m.bin = bin; m.mode = mode; m.start = 1'b1;
    lat = -1; busy_n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      m.start = 1'b0;
      if (m.busy) busy_n++;
      if (m.done) begin lat = c; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({m.busy, m.done, m.diff, m.bout, m.zero} !== {2'b00, 16'h0000, 2'b01}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b zero=%b, expected 0 0 0000 0 1",
               m.busy, m.done, m.diff, m.bout, m.zero);
    end
  endtask

  task automatic test_directed;
    logic [15:0] ta[6] = '{16'h1234, 16'h0000, 16'h0005, 16'h0005, 16'h0003, 16'h0010};
    logic [15:0] tb[6] = '{16'h0234, 16'h0001, 16'h0005, 16'h0005, 16'h0010, 16'h0003};
    logic        tbn[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        tm[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] exp_o[6] = '{{16'h1000, 2'b00}, {16'hFFFF, 2'b10}, {16'hFFFF, 2'b10},
                              {16'h0000, 2'b01}, {16'h000D, 2'b10}, {16'h000D, 2'b00}};
    int          exp_l[6] = '{5, 5, 5, 5, 9, 5};
    int lat, bn;
    for (int i = 0; i < 6; i++) begin
      op16(ta[i], tb[i], tbn[i], tm[i], lat, bn);
      checks++;
      if ({m.diff, m.bout, m.zero} !== exp_o[i]) begin
        errors++;
        $display("FAIL directed_%0d result: got %h/%b/%b, expected %h/%b/%b", i, m.diff, m.bout, m.zero,
                 exp_o[i][17:2], exp_o[i][1], exp_o[i][0]);
      end
      checks++;
      if (lat !== exp_l[i] || bn !== exp_l[i]) begin
        errors++;
        $display("FAIL directed_%0d latency: got done=%0d busy=%0d, expected %0d", i, lat, bn, exp_l[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    logic bin, mode;
    int lat, bn, d;
    bit bo, z;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); mode = 1'($urandom);
      if (i % 8 == 0) b = a;
      op16(a, b, bin, mode, lat, bn);
      ref_model(16, a, b, bin, mode, d, bo, z);
      checks++;
      if ({m.diff, m.bout, m.zero} !== {d[15:0], bo, z} || lat !== ((mode && a < b) ? 9 : 5)) begin
        errors++;
        $display("FAIL random a=%h b=%h bin=%b mode=%b: got %h/%b/%b lat=%0d, expected %h/%b/%b",
                 a, b, bin, mode, m.diff, m.bout, m.zero, lat, d[15:0], bo, z);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] xa, xb;
    int last, nd, d;
    bit bo, z;
    last = -1; nd = 0;
    @(negedge clk);
    xa = 16'($urandom); xb = 16'($urandom);
    m.a = xa; m.b = xb; m.bin = 1'b0; m.mode = 1'b0; m.start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (m.done) begin
        nd++;
        ref_model(16, xa, xb, 1'b0, 1'b0, d, bo, z);
        checks++;
        if ({m.diff, m.bout, m.zero} !== {d[15:0], bo, z} || (last >= 0 && c - last != 6)) begin
          errors++;
          $display("FAIL back_to_back c=%0d: got %h/%b/%b gap=%0d, expected %h/%b/%b gap=6",
                   c, m.diff, m.bout, m.zero, c - last, d[15:0], bo, z);
        end
        last = c;
        xa = 16'($urandom); xb = 16'($urandom);
        m.a = xa; m.b = xb; m.bin = 1'b0; m.mode = 1'b0;
      end else if (m.busy) begin
        m.a = 16'($urandom); m.b = 16'($urandom); m.bin = 1'b1; m.mode = 1'b1;
      end
    end
    m.start = 1'b0;
    checks++;
    if (nd !== 6) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d done pulses, expected 6", nd);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_midop;
    int lat, bn, nd;
    int k[2] = '{2, 6};
    for (int i = 0; i < 2; i++) begin
      op16(16'h1234, 16'h0234, 1'b0, 1'b0, lat, bn);
      @(negedge clk);
      m.a = 16'h0003; m.b = 16'h0010; m.bin = 1'b0; m.mode = 1'b1; m.start = 1'b1;
      @(negedge clk);
      m.start = 1'b0;
      repeat (k[i] - 1) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({m.busy, m.done, m.diff, m.bout, m.zero} !== {2'b00, 16'h0000, 2'b01}) begin
        errors++;
        $display("FAIL reset_midop_%0d: got busy=%b done=%b diff=%h bout=%b zero=%b, expected 0 0 0000 0 1",
                 i, m.busy, m.done, m.diff, m.bout, m.zero);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (12) begin
        @(negedge clk);
        if (m.done) nd++;
      end
      checks++;
      if (nd !== 0) begin
        errors++;
        $display("FAIL reset_midop_%0d_nodone: got %0d done pulses, expected 0", i, nd);
      end
      op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bn);
      checks++;
      if ({m.diff, m.bout, m.zero} !== {16'hFFFE, 2'b00} || lat !== 5) begin
        errors++;
        $display("FAIL reset_midop_%0d_after: got %h/%b/%b lat=%0d, expected fffe/0/0 lat=5",
                 i, m.diff, m.bout, m.zero, lat);
      end
    end
  endtask

  task automatic test_exhaustive;
    int lat[3], nn[3], d;
    logic [5:0] got[3];
    bit bo, z;
    nn = '{4, 2, 1};
    for (int md = 0; md < 2; md++)
      for (int bi = 0; bi < 2; bi++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            e1.a = 4'(a); e1.b = 4'(b); e1.bin = 1'(bi); e1.mode = 1'(md); e1.start = 1'b1;
            e2.a = 4'(a); e2.b = 4'(b); e2.bin = 1'(bi); e2.mode = 1'(md); e2.start = 1'b1;
            e4.a = 4'(a); e4.b = 4'(b); e4.bin = 1'(bi); e4.mode = 1'(md); e4.start = 1'b1;
            lat = '{-1, -1, -1};
            got = '{6'h0, 6'h0, 6'h0};
            for (int c = 1; c <= 12; c++) begin
              @(negedge clk);
              e1.start = 1'b0; e2.start = 1'b0; e4.start = 1'b0;
              if (e1.done && lat[0] < 0) begin lat[0] = c; got[0] = {e1.diff, e1.bout, e1.zero}; end
              if (e2.done && lat[1] < 0) begin lat[1] = c; got[1] = {e2.diff, e2.bout, e2.zero}; end
              if (e4.done && lat[2] < 0) begin lat[2] = c; got[2] = {e4.diff, e4.bout, e4.zero}; end
            end
            ref_model(4, a, b, 1'(bi), 1'(md), d, bo, z);
            for (int i = 0; i < 3; i++) begin
              checks++;
              if (got[i] !== {d[3:0], bo, z} || lat[i] !== ((md == 1 && a < b) ? 2 * nn[i] + 1 : nn[i] + 1)) begin
                errors++;
                $display("FAIL exhaustive N=%0d a=%0d b=%0d bin=%0d mode=%0d: got %b lat=%0d, expected %b",
                         nn[i], a, b, bi, md, got[i], lat[i], {d[3:0], bo, z});
              end
            end
          end
  endtask

  initial begin
    rst = 1'b1;
    m.start = 1'b0; m.a = '0; m.b = '0; m.bin = 1'b0; m.mode = 1'b0;
    e1.start = 1'b0; e1.a = '0; e1.b = '0; e1.bin = 1'b0; e1.mode = 1'b0;
    e2.start = 1'b0; e2.a = '0; e2.b = '0; e2.bin = 1'b0; e2.mode = 1'b0;
    e4.start = 1'b0; e4.a = '0; e4.b = '0; e4.bin = 1'b0; e4.mode = 1'b0;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_midop;
    test_exhaustive;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor that computes `A - B - bin`, or `|A - B|`, on WIDTH-bit operands, one DIGIT-bit slice per clock, LSB slice first. The borrow is carried between slices in a register. It generalises the single-bit full subtractor to arbitrary word widths with a start/busy/done handshake. It is intended for area-constrained datapaths where a full-width ripple subtractor is too large or too slow.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- N (derived, not overridable): WIDTH/DIGIT, the slices per pass.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = subtract (A-B-bin); 1 = absolute difference (bin ignored).
- a  input  WIDTH  minuend, captured at accepted start.
- b  input  WIDTH  subtrahend, captured at accepted start.
- bin  input  1  borrow-in, captured at accepted start.
- busy  output  1  high from cycle after accepted start until done cycle inclusive.
- done  output  1  single-cycle pulse; result valid.
- diff  output  WIDTH  result; held from done until next accepted start.
- bout  output  1  final borrow of first pass (1 ⇔ a < b + bin); held with diff.
- zero  output  1  diff == 0; held with diff.

## Operation
- FSM states: IDLE, PASS1, PASS2, DONE.
- IDLE, start=1:
  - Capture a, b, bin (forced 0 if mode=1) and mode.
  - Clear slice counter and diff; go to PASS1.
- PASS1, each cycle, for slice k = counter:
  - diff[k] ← a[k] - b[k] - borrow.
  - borrow ← slice borrow-out. Borrow starts at the captured bin.
  - Counter increments.
  - After slice N-1: if mode=1 and final borrow=1, go to PASS2; otherwise go to DONE. bout ← final borrow in either case.
- PASS2 (abs mode, a < b only):
  - Counter and borrow reset to 0; same slice operation with operands swapped (b - a).
  - After slice N-1, go to DONE; borrow-out is ignored.
- DONE: assert done; go to IDLE. busy deasserts the following cycle.
- start outside IDLE (busy=1 or DONE) is ignored; no queuing.
- Arithmetic is modulo 2^WIDTH; diff wraps. Example: 0x0000 - 0x0001 = 0xFFFF with bout=1.
- zero is evaluated on the final diff; it is registered together with done.

## Timing
- Reset (async, any state): state=IDLE; busy=0, done=0, diff=0, bout=0, zero=1. Internal counter and borrow are cleared.
- Reset mid-operation aborts the operation without a done pulse. The first rising edge after rst deasserts may accept start.
- Start accepted at edge T0. busy=1 from T0.
- Subtract, or abs with a ≥ b: PASS1 occupies N cycles; done=1 in cycle T0+N+1.
- Abs with a < b: done=1 in cycle T0+2N+1.
- The earliest next accepted start is the edge after the done cycle. Back-to-back throughput is one result per N+2 cycles.
- diff, bout and zero change only at the done edge or on reset. Partial slices are not visible during passes.
- DIGIT=WIDTH gives N=1; the handshake is identical.

## Structure
- Package serial_subtractor_pkg:
  - FSM state enum (IDLE, PASS1, PASS2, DONE).
  - Mode constants MODE_SUB=0, MODE_ABS=1.
  - Function computing the counter width, clog2(N) with minimum 1.
- Sub-module digit_subtractor #(DIGIT): combinational DIGIT-bit borrow-ripple chain.
  - Each bit: d = x^y^z, borrow = ~x&(y^z) | y&z.
  - Ports: x, y, bin in; d, bout out.
- Top level contains the FSM, counter, operand/borrow registers and a slice mux/demux indexed by the counter.
- Target size: roughly 150–250 lines total.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 unless stated.
- Subtract, a=0x1234, b=0x0234, bin=0 → diff=0x1000, bout=0, zero=0; done exactly 5 cycles after the start edge; busy high for 5 cycles.
- Subtract, a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1. Then a=b=0x0005 with bin=1 → diff=0xFFFF, bout=1. With bin=0 → diff=0x0000, zero=1.
- Abs mode:
  - a=0x0003, b=0x0010, bin=1 → diff=0x000D, bout=1; done at cycle 9.
  - a=0x0010, b=0x0003 → diff=0x000D, bout=0; done at cycle 5.
- Hold start high continuously: one result per 6 cycles. start pulses while busy produce no extra done pulse and do not disturb the in-flight result.
- Reset asserted mid-PASS1 and mid-PASS2:
  - Outputs immediately 0/1 (zero=1) with no done pulse.
  - A following start a=0xFFFF, b=0x0001 → diff=0xFFFE.
- Exhaustive run against a behavioural model: WIDTH=4 with DIGIT ∈ {1, 2, 4}, all a, b, bin and mode combinations; check diff, bout, zero and done latency.
